// File: rtl/bp_cfg_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bp_cfg_boot_sequencer
// Brief    : Post-reset sequencer that programs every core's config registers
//            over the I/O command channel, then releases all cores from freeze.
// Revision : 1.0 - initial release
// ============================================================================
module bp_cfg_boot_sequencer #(
    parameter int                       num_core_p        = 1,
    parameter int                       paddr_width_p     = 40,
    parameter int                       data_width_p      = 64,
    parameter int                       vaddr_width_p     = 39,
    parameter logic [paddr_width_p-1:0] cfg_base_addr_p   = 40'h00_0020_0000,
    parameter logic [paddr_width_p-1:0] core_stride_p     = 40'h00_0100_0000,
    parameter int                       max_outstanding_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [vaddr_width_p-1:0] boot_pc_i,
    input  logic                     cce_mode_i,
    output logic                     io_cmd_v_o,
    output logic [paddr_width_p-1:0] io_cmd_addr_o,
    output logic [data_width_p-1:0]  io_cmd_data_o,
    input  logic                     io_cmd_ready_i,
    input  logic                     io_resp_v_i,
    output logic                     io_resp_yumi_o,
    output logic                     done_o,
    output logic                     error_o
);

    localparam int C_CREDIT_W = $clog2(max_outstanding_p + 1);
    localparam int C_CORE_W   = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    localparam logic [C_CREDIT_W-1:0] C_MAX_CREDIT = C_CREDIT_W'(max_outstanding_p);
    localparam logic [C_CREDIT_W-1:0] C_CREDIT_ONE = C_CREDIT_W'(1);
    localparam logic [C_CORE_W-1:0]   C_LAST_CORE  = C_CORE_W'(num_core_p - 1);
    localparam logic [C_CORE_W-1:0]   C_CORE_ONE   = C_CORE_W'(1);

    localparam logic [2:0] e_reset    = 3'd0;
    localparam logic [2:0] e_config   = 3'd1;
    localparam logic [2:0] e_unfreeze = 3'd2;
    localparam logic [2:0] e_drain    = 3'd3;
    localparam logic [2:0] e_done     = 3'd4;

    logic [2:0]               state_q,    state_d;
    logic [C_CORE_W-1:0]      core_cnt_q, core_cnt_d;
    logic [1:0]               reg_cnt_q,  reg_cnt_d;
    logic [C_CREDIT_W-1:0]    credit_q,   credit_d;
    logic [vaddr_width_p-1:0] pc_q,       pc_d;
    logic                     mode_q,     mode_d;
    logic                     error_q,    error_d;
    logic [paddr_width_p-1:0] addr_q,     addr_d;
    logic [data_width_p-1:0]  data_q,     data_d;

    logic w_cmd_v;
    logic w_accept;
    logic w_ack_ok;

    function automatic logic [paddr_width_p-1:0] f_addr(
        input logic [C_CORE_W-1:0] core,
        input logic [1:0]          reg_idx
    );
        f_addr = cfg_base_addr_p
               + paddr_width_p'(core) * core_stride_p
               + paddr_width_p'({reg_idx, 3'b000});
    endfunction

    // Register order per core: freeze, core_id, cce_mode, npc
    function automatic logic [data_width_p-1:0] f_data(
        input logic [C_CORE_W-1:0]      core,
        input logic [1:0]               reg_idx,
        input logic                     mode,
        input logic [vaddr_width_p-1:0] pc
    );
        case (reg_idx)
            2'd0:    f_data = data_width_p'(1'b1);
            2'd1:    f_data = data_width_p'(core);
            2'd2:    f_data = data_width_p'(mode);
            default: f_data = data_width_p'(pc);
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        core_cnt_d = core_cnt_q;
        reg_cnt_d  = reg_cnt_q;
        pc_d       = pc_q;
        mode_d     = mode_q;

        w_cmd_v  = ((state_q == e_config) || (state_q == e_unfreeze)) && (credit_q < C_MAX_CREDIT);
        w_accept = w_cmd_v && io_cmd_ready_i;
        // An ack with nothing outstanding is only legal if it pairs with a same-cycle accept
        w_ack_ok = io_resp_v_i && ((credit_q != '0) || w_accept);
        error_d  = error_q || (io_resp_v_i && !w_ack_ok);

        case ({w_accept, w_ack_ok})
            2'b10:   credit_d = credit_q + C_CREDIT_ONE;
            2'b01:   credit_d = credit_q - C_CREDIT_ONE;
            default: credit_d = credit_q;
        endcase

        case (state_q)
            e_reset: begin
                pc_d       = boot_pc_i;
                mode_d     = cce_mode_i;
                core_cnt_d = '0;
                reg_cnt_d  = '0;
                state_d    = e_config;
            end
            e_config: begin
                if (w_accept) begin
                    reg_cnt_d = reg_cnt_q + 2'd1;
                    if (reg_cnt_q == 2'd3) begin
                        if (core_cnt_q == C_LAST_CORE) begin
                            core_cnt_d = '0;
                            state_d    = e_unfreeze;
                        end else begin
                            core_cnt_d = core_cnt_q + C_CORE_ONE;
                        end
                    end
                end
            end
            e_unfreeze: begin
                if (w_accept) begin
                    if (core_cnt_q == C_LAST_CORE) begin
                        core_cnt_d = '0;
                        state_d    = e_drain;
                    end else begin
                        core_cnt_d = core_cnt_q + C_CORE_ONE;
                    end
                end
            end
            e_drain: begin
                if (credit_d == '0) begin
                    state_d = e_done;
                end
            end
            e_done:  state_d = e_done;
            default: state_d = e_reset;
        endcase

        // Address/data are decoded from next state so they hold steady under backpressure
        if (state_d == e_config) begin
            addr_d = f_addr(core_cnt_d, reg_cnt_d);
            data_d = f_data(core_cnt_d, reg_cnt_d, mode_d, pc_d);
        end else if (state_d == e_unfreeze) begin
            addr_d = f_addr(core_cnt_d, 2'd0);
            data_d = '0;
        end else begin
            addr_d = '0;
            data_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_reset;
            core_cnt_q <= '0;
            reg_cnt_q  <= '0;
            credit_q   <= '0;
            pc_q       <= '0;
            mode_q     <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            core_cnt_q <= core_cnt_d;
            reg_cnt_q  <= reg_cnt_d;
            credit_q   <= credit_d;
            pc_q       <= pc_d;
            mode_q     <= mode_d;
            error_q    <= error_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign io_cmd_v_o     = w_cmd_v;
    assign io_cmd_addr_o  = addr_q;
    assign io_cmd_data_o  = data_q;
    assign io_resp_yumi_o = io_resp_v_i;
    assign done_o         = (state_q == e_done);
    assign error_o        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_cfg_boot_sequencer
// Brief    : Scoreboard bench for the boot sequencer (two-core and one-core DUTs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_cfg_boot_sequencer;

    typedef struct packed {
        logic [39:0] a;
        logic [63:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // two-core DUT
    logic        rst, mode, rdy, resp;
    logic [38:0] boot_pc;
    logic        v, yumi, done, err;
    logic [39:0] addr;
    logic [63:0] data;

    // single-core DUT
    logic        rst1, mode1, rdy1, resp1;
    logic [38:0] pc1;
    logic        v1, yumi1, done1, err1;
    logic [39:0] addr1;
    logic [63:0] data1;

    exp_t q[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   acc1_cnt = 0;
    int   tb_out = 0;
    bit   auto_ack = 1'b0;
    bit   acc1_last = 1'b0;
    bit   d1_finished = 1'b0;

    bp_cfg_boot_sequencer #(.num_core_p(2)) dut (
        .clk_i(clk), .reset_i(rst), .boot_pc_i(boot_pc), .cce_mode_i(mode),
        .io_cmd_v_o(v), .io_cmd_addr_o(addr), .io_cmd_data_o(data),
        .io_cmd_ready_i(rdy), .io_resp_v_i(resp), .io_resp_yumi_o(yumi),
        .done_o(done), .error_o(err)
    );

    bp_cfg_boot_sequencer #(.num_core_p(1)) dut1 (
        .clk_i(clk), .reset_i(rst1), .boot_pc_i(pc1), .cce_mode_i(mode1),
        .io_cmd_v_o(v1), .io_cmd_addr_o(addr1), .io_cmd_data_o(data1),
        .io_cmd_ready_i(rdy1), .io_resp_v_i(resp1), .io_resp_yumi_o(yumi1),
        .done_o(done1), .error_o(err1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_main();
        q.push_back({40'h0000200000, 64'h0});
        q[$].d = 64'h1;
        q.push_back({40'h0000200008, 64'h0});
        q.push_back({40'h0000200010, 64'h0});
        q.push_back({40'h0000200018, 64'h12345678});
        q.push_back({40'h0001200000, 64'h1});
        q.push_back({40'h0001200008, 64'h1});
        q.push_back({40'h0001200010, 64'h0});
        q.push_back({40'h0001200018, 64'h12345678});
        q.push_back({40'h0000200000, 64'h0});
        q.push_back({40'h0001200000, 64'h0});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack) resp = (tb_out > 0);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int c;
        c = 0;
        while (acc_cnt < n && c < budget) begin
            step();
            c++;
        end
        if (acc_cnt < n) begin
            checks++;
            errors++;
            $display("FAIL wait_accepts actual=%0d expected=%0d", acc_cnt, n);
        end
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done !== 1'b1 && c < budget) begin
            step();
            c++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    // monitor: two-core DUT
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (v && rdy) begin
                acc_cnt++;
                tb_out++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_write actual=%h/%h expected=none", addr, data);
                end else begin
                    e = q.pop_front();
                    check("wr_addr", 64'(addr), 64'(e.a));
                    check("wr_data", data, e.d);
                end
            end
            if (resp && tb_out > 0) tb_out--;
        end
    end

    // monitor: single-core DUT
    initial forever begin
        exp_t e;
        @(negedge clk);
        acc1_last = 1'b0;
        if (!rst1 && v1 && rdy1) begin
            acc1_last = 1'b1;
            acc1_cnt++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_write1 actual=%h/%h expected=none", addr1, data1);
            end else begin
                e = q1.pop_front();
                check("wr1_addr", 64'(addr1), 64'(e.a));
                check("wr1_data", data1, e.d);
            end
        end
    end

    // single-core driver: always ready, acknowledge the cycle after each accept
    initial begin
        int  acks;
        bit  pending;
        bit  seen;
        rst1 = 1'b1; rdy1 = 1'b1; resp1 = 1'b0;
        pc1 = 39'h0080000000; mode1 = 1'b1;
        acks = 0; pending = 1'b0; seen = 1'b0;
        q1.push_back({40'h0000200000, 64'h1});
        q1.push_back({40'h0000200008, 64'h0});
        q1.push_back({40'h0000200010, 64'h1});
        q1.push_back({40'h0000200018, 64'h80000000});
        q1.push_back({40'h0000200000, 64'h0});
        repeat (3) @(posedge clk);
        #1 rst1 = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (pending) begin
                check("done1_after_last_ack", 64'(done1), 64'd1);
                seen = 1'b1;
            end
            resp1 = acc1_last;
            if (resp1) begin
                acks++;
                if (acks == 5) begin
                    check("done1_before_last_ack", 64'(done1), 64'd0);
                    pending = 1'b1;
                end
            end
        end
        resp1 = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done1_timeout actual=%0d expected=5 acks", acks);
        end
        repeat (4) @(posedge clk);
        #1;
        check("single_total_writes", 64'(acc1_cnt), 64'd5);
        check("single_queue_empty", 64'(q1.size()), 64'd0);
        check("single_no_error", 64'(err1), 64'd0);
        d1_finished = 1'b1;
    end

    // two-core driver
    initial begin
        int base;
        rst = 1'b1; rdy = 1'b0; resp = 1'b0;
        boot_pc = 39'h12345678; mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_v", 64'(v), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(err), 64'd0);
        resp = 1'b1;
        #1 check("yumi_follows_1", 64'(yumi), 64'd1);
        resp = 1'b0;
        #1 check("yumi_follows_0", 64'(yumi), 64'd0);

        push_main();
        rst = 1'b0;
        #1 check("v_in_e_reset", 64'(v), 64'd0);
        step();
        check("v_first_cmd", 64'(v), 64'd1);

        // backpressure: first command must hold for 7 stalled cycles
        for (int i = 0; i < 7; i++) begin
            check("bp_valid", 64'(v), 64'd1);
            check("bp_addr", 64'(addr), 64'h200000);
            check("bp_data", data, 64'h1);
            step();
        end
        rdy = 1'b1;

        wait_acc(4, 20);
        repeat (3) step();
        check("credit_stall_count", 64'(acc_cnt), 64'd4);
        check("credit_stall_v", 64'(v), 64'd0);

        resp = 1'b1;
        step();
        resp = 1'b0;
        repeat (3) step();
        check("one_ack_one_cmd", 64'(acc_cnt), 64'd5);
        check("one_ack_v", 64'(v), 64'd0);

        // ack in the stall cycle, then ack paired with an accept
        resp = 1'b1;
        step();
        step();
        resp = 1'b0;
        repeat (3) step();
        check("same_cycle_count", 64'(acc_cnt), 64'd7);
        check("same_cycle_v", 64'(v), 64'd0);

        auto_ack = 1'b1;
        wait_done(200);
        auto_ack = 1'b0;
        resp = 1'b0;
        step();
        check("total_writes", 64'(acc_cnt), 64'd10);
        check("queue_empty", 64'(q.size()), 64'd0);
        check("no_error", 64'(err), 64'd0);

        resp = 1'b1;
        step();
        resp = 1'b0;
        step();
        check("spurious_error", 64'(err), 64'd1);
        check("spurious_done", 64'(done), 64'd1);
        repeat (5) step();
        check("error_sticky", 64'(err), 64'd1);
        check("done_sticky", 64'(done), 64'd1);
        check("done_no_cmd", 64'(v), 64'd0);

        rst = 1'b1;
        step();
        check("error_cleared", 64'(err), 64'd0);
        push_main();
        base = acc_cnt;
        rst = 1'b0;
        auto_ack = 1'b1;
        wait_acc(base + 3, 20);
        rst = 1'b1;
        auto_ack = 1'b0;
        resp = 1'b0;
        #1;
        check("midrst_v", 64'(v), 64'd0);
        check("midrst_addr", 64'(addr), 64'd0);
        check("midrst_data", data, 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_error", 64'(err), 64'd0);
        q.delete();
        tb_out = 0;
        step();
        step();
        push_main();
        base = acc_cnt;
        rst = 1'b0;
        auto_ack = 1'b1;
        wait_done(200);
        auto_ack = 1'b0;
        resp = 1'b0;
        step();
        check("restart_writes", 64'(acc_cnt - base), 64'd10);
        check("restart_queue_empty", 64'(q.size()), 64'd0);
        check("restart_no_error", 64'(err), 64'd0);

        for (int c = 0; c < 200 && !d1_finished; c++) step();
        if (!d1_finished) begin
            checks++;
            errors++;
            $display("FAIL single_core_timeout actual=0 expected=1");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_cfg_boot_sequencer.md
# bp_cfg_boot_sequencer

Post-reset configuration sequencer that consumes the selected processor configuration (core count from `cc_x_dim * cc_y_dim`) and programs every core tile's configuration registers over the I/O command channel. It issues a fixed program of memory-mapped writes per core and tracks outstanding writes with a credit counter. It releases all cores from freeze only after every core has been programmed. It sits between the top-level parameter selection and the I/O NoC command port of the core complex, and replaces hand-built boot stimulus in testbenches and the chip top.

## Interface
- `num_core_p`, default 1: number of cores to program; equals `cc_x_dim * cc_y_dim` of the active config.
- `paddr_width_p`, default 40: command address width.
- `data_width_p`, default 64: command data width.
- `vaddr_width_p`, default 39: boot PC width.
- `cfg_base_addr_p`, default 40'h00_0020_0000: configuration block offset inside a tile.
- `core_stride_p`, default 40'h00_0100_0000: address distance between consecutive cores.
- `max_outstanding_p`, default 4: maximum unacknowledged writes (at least 1).
- `clk_i`, in, 1: clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `boot_pc_i`, in, `vaddr_width_p`: PC written to every core; sampled when leaving reset and held internally.
- `cce_mode_i`, in, 1: coherence mode written to every core (0 = uncached, 1 = normal); sampled with `boot_pc_i`.
- `io_cmd_v_o`, out, 1: write command valid.
- `io_cmd_addr_o`, out, `paddr_width_p`: write address.
- `io_cmd_data_o`, out, `data_width_p`: write data, zero-extended.
- `io_cmd_ready_i`, in, 1: command accepted when `io_cmd_v_o & io_cmd_ready_i`.
- `io_resp_v_i`, in, 1: write acknowledge.
- `io_resp_yumi_o`, out, 1: equals `io_resp_v_i`; acknowledges are always consumed in the same cycle.
- `done_o`, out, 1: all writes issued and acknowledged.
- `error_o`, out, 1: sticky; an acknowledge arrived with zero outstanding writes.

## Operation
- Register offsets: freeze is 0x00, core_id is 0x08, cce_mode is 0x10, npc is 0x18.
- Address for core `i` at offset `o`: `cfg_base_addr_p + i*core_stride_p + o`, truncated to `paddr_width_p`.
- The FSM has five states: `e_reset`, `e_config`, `e_unfreeze`, `e_drain`, `e_done`.
- **`e_reset`** (state entered by reset):
  - Capture `boot_pc_i` and `cce_mode_i`.
  - Clear `core_cnt`, `reg_cnt`, the credit counter and `error_o`.
  - Next cycle, go to `e_config`.
- **`e_config`**:
  - For each core in order 0..`num_core_p-1`, write four registers in order `reg_cnt` 0..3: freeze = 1, core_id = `core_cnt`, cce_mode = captured value, npc = captured PC.
  - `reg_cnt` increments on every accepted command.
  - When `reg_cnt` wraps from 3 to 0, `core_cnt` increments.
  - After the last core's npc write, `core_cnt` clears and the FSM goes to `e_unfreeze`.
- **`e_unfreeze`**:
  - Write freeze = 0 to each core in order 0..`num_core_p-1`.
  - After the last accepted write, go to `e_drain`.
- **`e_drain`**: wait until the credit count is 0, then go to `e_done`.
- **`e_done`**: terminal state; `done_o` = 1 and no further commands are issued.
- Credits:
  - The counter width is `clog2(max_outstanding_p+1)`.
  - +1 on an accepted command; −1 on `io_resp_v_i`.
  - When both happen in the same cycle, the counter is unchanged.
- `io_cmd_v_o` = (state is `e_config` or `e_unfreeze`) & (credits < `max_outstanding_p`).
- Total writes issued: exactly `5*num_core_p`.
- `error_o`:
  - Set when `io_resp_v_i` is high while credits = 0 and no command is accepted in that cycle.
  - In that case the counter does not underflow (it stays 0).
  - `error_o` clears only on reset.

## Timing
- Reset values of outputs: `io_cmd_v_o` = 0, `io_cmd_addr_o` = 0, `io_cmd_data_o` = 0, `io_resp_yumi_o` follows `io_resp_v_i`, `done_o` = 0, `error_o` = 0.
- First command: `io_cmd_v_o` rises in the second cycle after `reset_i` deasserts (one cycle in `e_reset`).
- Address and data are registered state decodes.
  - They are stable while `io_cmd_v_o` is high and `io_cmd_ready_i` is low.
  - `io_cmd_v_o` never drops without a handshake, except by reset.
- Throughput: one command per cycle while ready stays high and credits are available.
- Credit limit: with `max_outstanding_p` writes unacknowledged, `io_cmd_v_o` = 0. It reasserts in the cycle after an acknowledge.
- `done_o` rises one cycle after the final acknowledge brings credits to 0 in `e_drain`.
- Reset mid-operation: asynchronous return to `e_reset` with all counters cleared. In-flight acknowledges arriving after reset set `error_o`.

## Test plan
- **Single core, always ready, immediate acknowledge.** Config: `num_core_p`=1, `boot_pc_i`=39'h0080000000, `cce_mode_i`=1.
  - Expect exactly 5 writes, in order: (0x200000, 1), (0x200008, 0), (0x200010, 1), (0x200018, 0x80000000), (0x200000, 0).
  - Expect `done_o` = 1 one cycle after the 5th acknowledge.
- **Two cores, ordering and release.** Config: `num_core_p`=2.
  - All 8 programming writes (cores 0 then 1) must precede both unfreeze writes.
  - Core 1 addresses start at 0x1200000, and its core_id data is 1.
- **Backpressure.** Drive `io_cmd_ready_i` low for 7 cycles while valid is high.
  - Address and data must be held constant.
  - There must be no duplicate or dropped writes (total still 5).
- **Credit limit.** Config: `max_outstanding_p`=4; withhold acknowledges.
  - Valid must drop after 4 accepts.
  - One acknowledge must let exactly one more command through.
  - A simultaneous accept and acknowledge must leave the count unchanged.
- **Spurious acknowledge.** Pulse `io_resp_v_i` in `e_done`.
  - `error_o` goes to 1 and stays 1.
  - `done_o` stays 1.
- **Reset mid-sequence.** Assert `reset_i` after the 3rd accept.
  - All outputs are at reset values immediately.
  - After release, the sequence restarts at core 0, offset 0x00.
